// File: rtl/fetch_buf.sv
// IF/ID boundary buffer: a DEPTH-entry FIFO of (pc, inst) in front of the ID output register,
// so fetch keeps running while decode is stalled until the queue fills.
module fetch_buf #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned INST_W    = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned OUT_STAGE = 2,
    parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [5:0]        stall,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [CNT_W-1:0]  buf_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
    logic [INST_W-1:0] r_inst_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_id_valid;
    logic [ADDR_W-1:0] r_id_pc;
    logic [INST_W-1:0] r_id_inst;

    logic w_advance;
    logic w_accept;
    logic w_empty;
    logic w_clear;
    logic w_pop;
    logic w_push;
    logic w_bypass;
    logic w_unused_stall;

    assign w_advance      = ~stall[OUT_STAGE];
    assign w_empty        = (r_count == '0);
    assign if_ready       = (r_count != CNT_W'(DEPTH));
    assign w_accept       = if_valid & if_ready;
    assign w_clear        = rst | flush;
    assign w_pop          = w_advance & ~w_empty;
    // Bypass only when nothing is queued, so an incoming word can never overtake the queue.
    assign w_bypass       = w_advance & w_empty & w_accept;
    assign w_push         = w_accept & ~w_bypass;
    assign w_unused_stall = ^stall;

    always_ff @(posedge clk) begin
        if (!w_clear && w_push) begin
            r_pc_mem[r_tail]   <= if_pc;
            r_inst_mem[r_tail] <= if_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_id_inst  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end

            if (w_advance) begin
                if (w_pop) begin
                    r_id_valid <= 1'b1;
                    r_id_pc    <= r_pc_mem[r_head];
                    r_id_inst  <= r_inst_mem[r_head];
                end else if (w_bypass) begin
                    r_id_valid <= 1'b1;
                    r_id_pc    <= if_pc;
                    r_id_inst  <= if_inst;
                end else begin
                    r_id_valid <= 1'b0;
                    r_id_pc    <= '0;
                    r_id_inst  <= '0;
                end
            end
        end
    end

    assign id_valid  = r_id_valid;
    assign id_pc     = r_id_pc;
    assign id_inst   = r_id_inst;
    assign buf_count = r_count;

endmodule
